control_unit: RTL and testbench

Hardwired Moore control sequencer for the Phase 2 single-bus datapath. It steps every instruction through a fetch sequence and then an opcode-specific execute sequence. Each state drives the bus-gate, register-load, memory and ALU-select strobes, including Gra/Grb/Grc/Rin/Rout/BAout, which the select-and-encode logic decodes into per-register enables. It also implements halt and an external stop/resume.

---
 rtl/control_unit.sv | 133 +++++++++++++
 tb/tb_control_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer driving fetch/execute strobes for the single-bus datapath
module control_unit #(
    parameter int BITS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stop,
    input  logic [BITS-1:0] IR,
    input  logic            con_ff,
    output logic            PCout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Cout,
    output logic            PCin,
    output logic            IRin,
    output logic            MARin,
    output logic            MDRin,
    output logic            Yin,
    output logic            Zin,
    output logic            CONin,
    output logic            IncPC,
    output logic            Read,
    output logic            Write,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [4:0]      alu_op,
    output logic            run
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b01001;
    localparam logic [4:0] OP_OR   = 5'b01010;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_op;
    logic [4:0] w_imm_alu;
    logic       w_rfmt, w_imm, w_ld, w_ldi, w_st, w_ldx, w_br, w_jr, w_halt, w_last;
    logic       w_unused;

    assign w_op      = IR[BITS-1 -: 5];
    assign w_unused  = ^IR[BITS-6:0];
    assign w_rfmt    = (w_op >= OP_ADD) && (w_op <= OP_OR);
    assign w_imm     = (w_op >= OP_ADDI) && (w_op <= 5'b01101);
    assign w_imm_alu = (w_op == OP_ADDI) ? OP_ADD : (w_op == OP_ANDI) ? OP_AND : OP_OR;
    assign w_ld      = w_op == OP_LD;
    assign w_ldi     = w_op == OP_LDI;
    assign w_st      = w_op == OP_ST;
    assign w_ldx     = w_ld || w_ldi || w_st;
    assign w_br      = w_op == OP_BR;
    assign w_jr      = w_op == OP_JR;
    assign w_halt    = w_op == OP_HALT;
    // last execute step of the current opcode, where the instruction returns to fetch (or PAUSE)
    assign w_last    = (r_state == S_T3 && !(w_rfmt || w_imm || w_ldx || w_br))
                    || (r_state == S_T5 && (w_rfmt || w_imm || w_ldi))
                    || (r_state == S_T6 && w_br)
                    || (r_state == S_T7);

    // state register; reset overrides every other transition
    always_ff @(posedge clock) begin
        r_state <= reset ? S_RST : w_next;
    end

    // next-state: linear T-step progression, stop honoured only at instruction boundaries
    always_comb begin
        w_next = state_t'(r_state + 4'd1);
        case (r_state)
            S_RST:   w_next = S_T0;
            S_PAUSE: w_next = stop ? S_PAUSE : S_T0;
            S_HALT:  w_next = S_HALT;
            default: begin
                if (r_state == S_T3 && w_halt) w_next = S_HALT;
                else if (w_last)               w_next = stop ? S_PAUSE : S_T0;
            end
        endcase
    end

    // Moore strobe decode from the state and the opcode held in IR
    always_comb begin
        {PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC} = '0;
        {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
        alu_op = '0;
        run    = !(r_state inside {S_RST, S_PAUSE, S_HALT});
        case (r_state)
            S_T0: {PCout, MARin, IncPC, Zin} = '1;
            S_T1: {Zlowout, PCin, Read, MDRin} = '1;
            S_T2: {MDRout, IRin} = '1;
            S_T3: begin
                if (w_rfmt || w_imm) {Grb, Rout, Yin} = '1;
                else if (w_ldx)      {Grb, BAout, Yin} = '1;
                else if (w_br)       {Gra, Rout, CONin} = '1;
                else if (w_jr)       {Gra, Rout, PCin} = '1;
            end
            S_T4: begin
                if (w_rfmt)     {Grc, Rout, Zin} = '1;
                else if (w_imm || w_ldx) {Cout, Zin} = '1;
                else if (w_br)  {PCout, Yin} = '1;
                alu_op = w_rfmt ? w_op : w_imm ? w_imm_alu : w_ldx ? OP_ADD : 5'd0;
            end
            S_T5: begin
                if (w_rfmt || w_imm || w_ldi) {Zlowout, Gra, Rin} = '1;
                else if (w_ld || w_st)        {Zlowout, MARin} = '1;
                else if (w_br)                {Cout, Zin} = '1;
                alu_op = w_br ? OP_ADD : 5'd0;
            end
            S_T6: begin
                if (w_ld)      {Read, MDRin} = '1;
                else if (w_st) {Gra, Rout, MDRin} = '1;
                else if (w_br) {Zlowout, PCin} = {2{con_ff}};
            end
            S_T7: begin
                if (w_ld)      {MDRout, Gra, Rin} = '1;
                else if (w_st) Write = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench comparing per-cycle strobes against a table-driven model
module tb_control_unit;
    logic        clock = 1'b0, reset = 1'b1, stop = 1'b0, con_ff = 1'b0;
    logic [31:0] IR = '0;
    logic        PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC;
    logic        Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run;
    logic [4:0]  alu_op;

    always #5 clock = ~clock;

    control_unit #(.BITS(32)) dut (
        .clock(clock), .reset(reset), .stop(stop), .IR(IR), .con_ff(con_ff),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Cout(Cout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
        .CONin(CONin), .IncPC(IncPC), .Read(Read), .Write(Write),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .alu_op(alu_op), .run(run)
    );

    localparam logic [25:0] PCO  = 26'd1 << 25, ZLO  = 26'd1 << 24, MDRO = 26'd1 << 23;
    localparam logic [25:0] COUT = 26'd1 << 22, PCI  = 26'd1 << 21, IRI  = 26'd1 << 20;
    localparam logic [25:0] MARI = 26'd1 << 19, MDRI = 26'd1 << 18, YIN  = 26'd1 << 17;
    localparam logic [25:0] ZIN  = 26'd1 << 16, CONI = 26'd1 << 15, INC  = 26'd1 << 14;
    localparam logic [25:0] RD   = 26'd1 << 13, WR   = 26'd1 << 12, GRA  = 26'd1 << 11;
    localparam logic [25:0] GRB  = 26'd1 << 10, GRC  = 26'd1 << 9,  RIN  = 26'd1 << 8;
    localparam logic [25:0] RO   = 26'd1 << 7,  BA   = 26'd1 << 6,  RUN  = 26'd1;

    logic [25:0] obs, e;
    assign obs = {PCout, Zlowout, MDRout, Cout, PCin, IRin, MARin, MDRin, Yin, Zin, CONin, IncPC,
                  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_op, run};

    logic [25:0] exp_q[$], seq[$];
    string       lbl_q[$], l;
    int          compared = 0, mismatched = 0;

    function automatic logic [25:0] alu(input logic [4:0] x);
        return {20'd0, x, 1'b0};
    endfunction

    // expected strobe sets per cycle, straight from the instruction tables
    task automatic build(input logic [4:0] op, input logic con);
        seq = {PCO | MARI | INC | ZIN, ZLO | PCI | RD | MDRI, MDRO | IRI};
        if (op >= 5'd3 && op <= 5'd10)
            seq = {seq, GRB | RO | YIN, GRC | RO | ZIN | alu(op), ZLO | GRA | RIN};
        else if (op >= 5'd11 && op <= 5'd13)
            seq = {seq, GRB | RO | YIN, COUT | ZIN | alu(op == 5'd11 ? 5'd3 : op == 5'd12 ? 5'd9 : 5'd10),
                   ZLO | GRA | RIN};
        else if (op == 5'd0)
            seq = {seq, GRB | BA | YIN, COUT | ZIN | alu(5'd3), ZLO | MARI, RD | MDRI, MDRO | GRA | RIN};
        else if (op == 5'd1)
            seq = {seq, GRB | BA | YIN, COUT | ZIN | alu(5'd3), ZLO | GRA | RIN};
        else if (op == 5'd2)
            seq = {seq, GRB | BA | YIN, COUT | ZIN | alu(5'd3), ZLO | MARI, GRA | RO | MDRI, WR};
        else if (op == 5'd18)
            seq = {seq, GRA | RO | CONI, PCO | YIN, COUT | ZIN | alu(5'd3), con ? (ZLO | PCI) : 26'd0};
        else if (op == 5'd19)
            seq = {seq, GRA | RO | PCI};
        else
            seq = {seq, 26'd0};
        foreach (seq[i]) seq[i] = seq[i] | RUN;
    endtask

    task automatic push(input logic [25:0] v, input string s);
        exp_q.push_back(v);
        lbl_q.push_back(s);
    endtask

    // runs one instruction from T0; optionally raises stop at step stop_at or leaves at step reset_at
    task automatic exec(input logic [31:0] ir, input logic con, input bit stop_en, input int reset_at);
        int n, m, stop_at;
        IR = ir;
        con_ff = con;
        build(ir[31:27], con);
        n = seq.size();
        stop_at = stop_en ? int'($urandom_range(0, n - 1)) : -1;
        m = (reset_at >= 0) ? reset_at : n;
        for (int i = 0; i < ((reset_at >= 0) ? reset_at + 1 : n); i++)
            push(seq[i], $sformatf("op%0d_T%0d", ir[31:27], i));
        for (int i = 0; i < m; i++) begin
            if (i == stop_at) stop = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    task automatic exec_at(input logic [31:0] ir, input logic con, input int stop_step);
        build(ir[31:27], con);
        IR = ir;
        con_ff = con;
        for (int i = 0; i < seq.size(); i++) push(seq[i], $sformatf("op%0d_T%0d", ir[31:27], i));
        for (int i = 0; i < seq.size(); i++) begin
            if (i == stop_step) stop = 1'b1;
            @(posedge clock); #1;
        end
    endtask

    task automatic do_pause(input int k);
        for (int i = 0; i < k; i++) begin
            push(26'd0, "pause");
            if (i == k - 1) stop = 1'b0;
            @(posedge clock); #1;
        end
    endtask

    // holds reset for two edges from the current cycle, then releases into T0
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        push(26'd0, "rst");
        @(posedge clock); #1;
        push(26'd0, "rst");
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            compared++;
            if (obs !== e) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", l, obs, e);
            end
        end
    end

    function automatic logic [31:0] rand_ir(input logic [4:0] op);
        logic [31:0] r;
        r = $urandom;
        return {op, r[26:0]};
    endfunction

    initial begin
        logic [4:0] op;
        do_reset();
        exec(32'h18D09042, 1'b0, 1'b0, -1);
        exec_at(32'h18D09042, 1'b0, 4);
        do_pause(2);
        exec(rand_ir(5'd0), 1'b0, 1'b0, -1);
        exec(rand_ir(5'd2), 1'b1, 1'b0, -1);
        exec(rand_ir(5'd18), 1'b1, 1'b0, -1);
        exec(rand_ir(5'd18), 1'b0, 1'b0, -1);
        exec(rand_ir(5'd19), 1'b0, 1'b0, -1);
        exec(rand_ir(5'd25), 1'b0, 1'b0, -1);
        exec(rand_ir(5'd11), 1'b0, 1'b0, -1);
        exec(rand_ir(5'd1), 1'b0, 1'b0, -1);
        exec(rand_ir(5'd0), 1'b0, 1'b0, 5);
        do_reset();
        for (int k = 0; k < 60; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd26) op = 5'd25;
            if ($urandom_range(0, 3) == 0) begin
                exec(rand_ir(op), 1'($urandom), 1'b1, -1);
                do_pause(int'($urandom_range(1, 3)));
            end else
                exec(rand_ir(op), 1'($urandom), 1'b0, -1);
        end
        exec_at(rand_ir(5'd26), 1'b0, 3);
        for (int k = 0; k < 6; k++) begin
            push(26'd0, "halt");
            stop = 1'($urandom);
            @(posedge clock); #1;
        end
        stop = 1'b0;
        push(26'd0, "halt");
        do_reset();
        exec(rand_ir(5'd4), 1'b0, 1'b0, -1);
        @(negedge clock); #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
